// File: rtl/bus_pkg.sv
// bus_pkg: shared widths, mode encoding and slave port state encoding for the serial bus.
package bus_pkg;
   localparam int ADDR_WIDTH = 12;
   localparam int DATA_WIDTH = 8;
   localparam int SLAVE_SEL_BITS = 2;
   localparam logic MODE_READ = 1'b1;
   localparam logic MODE_WRITE = 1'b0;
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_WRITE, S_READ, S_WAIT, S_RDATA} state_t;
endpackage

// File: rtl/slave_piso.sv
// slave_piso: parallel-load, serial-out register that returns read data LSB first.
module slave_piso #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] d,
   output logic         q
);
   logic [W-1:0] sr;
   always_ff @(posedge clk)
      if (reset) sr <= '0;
      else if (load) sr <= d;
      else if (shift) sr <= {1'b0, sr[W-1:1]};
   assign q = sr[0];
endmodule

// File: rtl/serial_slave_port.sv
// serial_slave_port: deserialises a mode/address/data frame from the serial bus,
// performs one local memory access and serialises read data back.
module serial_slave_port
   import bus_pkg::*;
#(
   parameter int ADDR_WIDTH = bus_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = bus_pkg::DATA_WIDTH,
   parameter int MEM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s_sel,
   input  logic                  s_valid,
   input  logic                  s_wdata,
   output logic                  s_ready,
   output logic                  s_rdata,
   output logic                  s_rvalid,
   output logic                  txn_done,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   output logic                  mem_re,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);
   localparam int CW = $clog2(ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH) + 1;
   localparam int LW = $clog2(MEM_LATENCY) + 1;
   state_t state;
   logic [CW-1:0] cnt;
   logic [LW-1:0] lat;
   logic mode, take, piso_q, last_wait;
   // s_ready is gated by reset directly so it reads 0 throughout reset and 1 right after release
   assign s_ready = !reset && (state == S_IDLE || state == S_ADDR || state == S_WDATA);
   assign take = s_sel && s_valid && s_ready;
   assign last_wait = state == S_WAIT && lat == LW'(MEM_LATENCY - 1);
   assign s_rdata = s_rvalid & piso_q;
   slave_piso #(.W(DATA_WIDTH)) u_piso (
      .clk(clk),
      .reset(reset),
      .load(last_wait),
      .shift(state == S_RDATA),
      .d(mem_rdata),
      .q(piso_q)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt <= '0;
         lat <= '0;
         mode <= MODE_WRITE;
         mem_addr <= '0;
         mem_wdata <= '0;
         mem_we <= 1'b0;
         mem_re <= 1'b0;
         txn_done <= 1'b0;
         s_rvalid <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         mem_re <= 1'b0;
         txn_done <= 1'b0;
         case (state)
            S_IDLE: if (take) begin
               mode <= s_wdata;
               cnt <= '0;
               state <= S_ADDR;
            end
            S_ADDR: if (!s_sel) begin
               cnt <= '0;
               state <= S_IDLE;
            end else if (take) begin
               mem_addr <= {s_wdata, mem_addr[ADDR_WIDTH-1:1]};
               if (cnt == CW'(ADDR_WIDTH - 1)) begin
                  cnt <= '0;
                  state <= mode == MODE_WRITE ? S_WDATA : S_READ;
                  mem_re <= mode == MODE_READ;
               end else cnt <= cnt + 1'b1;
            end
            S_WDATA: if (!s_sel) begin
               cnt <= '0;
               state <= S_IDLE;
            end else if (take) begin
               mem_wdata <= {s_wdata, mem_wdata[DATA_WIDTH-1:1]};
               if (cnt == CW'(DATA_WIDTH - 1)) begin
                  cnt <= '0;
                  state <= S_WRITE;
                  mem_we <= 1'b1;
                  txn_done <= 1'b1;
               end else cnt <= cnt + 1'b1;
            end
            S_WRITE: state <= S_IDLE;
            S_READ: begin
               lat <= '0;
               state <= S_WAIT;
            end
            S_WAIT: if (last_wait) begin
               lat <= '0;
               cnt <= '0;
               s_rvalid <= 1'b1;
               txn_done <= DATA_WIDTH == 1;
               state <= S_RDATA;
            end else lat <= lat + 1'b1;
            S_RDATA: if (cnt == CW'(DATA_WIDTH - 1)) begin
               cnt <= '0;
               s_rvalid <= 1'b0;
               state <= S_IDLE;
            end else begin
               cnt <= cnt + 1'b1;
               txn_done <= cnt == CW'(DATA_WIDTH - 2);
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_slave_port.sv
// tb_serial_slave_port: directed frames against a latency-1 memory model with immediate-assertion checks.
module tb_serial_slave_port;
   logic clk = 1'b0, reset = 1'b1, s_sel = 1'b0, s_valid = 1'b0, s_wdata = 1'b0;
   logic s_ready, s_rdata, s_rvalid, txn_done, mem_we, mem_re;
   logic [11:0] mem_addr;
   logic [7:0] mem_wdata, mem_rdata = 8'h00;
   logic [7:0] mem [4096];
   int vectors = 0, miscompares = 0, we_cnt = 0, re_cnt = 0;
   serial_slave_port dut (
      .clk(clk), .reset(reset), .s_sel(s_sel), .s_valid(s_valid), .s_wdata(s_wdata),
      .s_ready(s_ready), .s_rdata(s_rdata), .s_rvalid(s_rvalid), .txn_done(txn_done),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
      if (mem_we) we_cnt <= we_cnt + 1;
      if (mem_re) re_cnt <= re_cnt + 1;
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic send_bit(input logic b, input bit gap);
      if (gap) begin
         s_valid = 1'b0;
         tick();
      end
      s_valid = 1'b1;
      s_wdata = b;
      tick();
      s_valid = 1'b0;
   endtask
   task automatic send_frame(input logic m, input logic [11:0] a, input logic [7:0] d, input bit gap);
      send_bit(m, gap);
      for (int i = 0; i < 12; i++) send_bit(a[i], gap);
      if (!m) for (int i = 0; i < 8; i++) send_bit(d[i], gap);
   endtask
   task automatic chk_write(input string tag, input logic [11:0] a, input logic [7:0] d);
      int w0;
      w0 = we_cnt;
      chk({tag, "_we"}, mem_we, 1);
      chk({tag, "_done"}, txn_done, 1);
      chk({tag, "_addr"}, mem_addr, a);
      chk({tag, "_wdata"}, mem_wdata, d);
      chk({tag, "_rdy0"}, s_ready, 0);
      tick();
      chk({tag, "_we_off"}, mem_we, 0);
      chk({tag, "_we_once"}, we_cnt, w0 + 1);
      chk({tag, "_rdy1"}, s_ready, 1);
   endtask
   task automatic chk_read(input string tag, input logic [11:0] a, input logic [7:0] d);
      chk({tag, "_re"}, mem_re, 1);
      chk({tag, "_raddr"}, mem_addr, a);
      chk({tag, "_rdy"}, s_ready, 0);
      tick();
      chk({tag, "_wait_rv"}, s_rvalid, 0);
      chk({tag, "_wait_re"}, mem_re, 0);
      tick();
      for (int i = 0; i < 8; i++) begin
         chk({tag, "_rv"}, s_rvalid, 1);
         chk({tag, "_bit"}, s_rdata, d[i]);
         chk({tag, "_done"}, txn_done, i == 7);
         chk({tag, "_rdy_rd"}, s_ready, 0);
         tick();
      end
      chk({tag, "_rv_end"}, s_rvalid, 0);
      chk({tag, "_done_end"}, txn_done, 0);
   endtask
   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      tick();
      tick();
      chk("rst_ready", s_ready, 0);
      chk("rst_outs", {s_rdata, s_rvalid, txn_done, mem_we, mem_re}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      reset = 1'b0;
      s_sel = 1'b1;
      #1;
      chk("post_rst_ready", s_ready, 1);
      send_frame(1'b0, 12'd1001, 8'd101, 1'b0);
      chk_write("wr1", 12'd1001, 8'd101);
      send_frame(1'b1, 12'd1001, 8'd0, 1'b0);
      chk_read("rd1", 12'd1001, 8'd101);
      send_frame(1'b0, 12'd1001, 8'd102, 1'b1);
      chk_write("gap", 12'd1001, 8'd102);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
      s_sel = 1'b0;
      tick();
      s_sel = 1'b1;
      chk("abort_ready", s_ready, 1);
      chk("abort_no_we", we_cnt, 2);
      chk("abort_no_re", re_cnt, 1);
      send_frame(1'b0, 12'd1002, 8'd7, 1'b0);
      chk_write("post_abort", 12'd1002, 8'd7);
      send_frame(1'b1, 12'd1001, 8'd0, 1'b0);
      s_valid = 1'b1;
      s_wdata = 1'b0;
      chk_read("ign", 12'd1001, 8'd102);
      chk("ign_idle_ready", s_ready, 1);
      tick();
      for (int i = 0; i < 12; i++) begin
         s_wdata = i == 0 || i == 2;
         tick();
      end
      for (int i = 0; i < 8; i++) begin
         s_wdata = i >= 2 && i <= 5;
         tick();
      end
      s_valid = 1'b0;
      chk_write("b2b", 12'd5, 8'h3C);
      send_frame(1'b1, 12'd1002, 8'd0, 1'b0);
      chk("mr_re", mem_re, 1);
      tick();
      tick();
      chk("mr_bit0", s_rdata, 1);
      tick();
      chk("mr_bit1", s_rdata, 1);
      tick();
      chk("mr_bit2_rv", s_rvalid, 1);
      chk("mr_bit2", s_rdata, 1);
      reset = 1'b1;
      tick();
      chk("mr_rv", s_rvalid, 0);
      chk("mr_ready", s_ready, 0);
      chk("mr_outs", {s_rdata, txn_done, mem_we, mem_re}, 0);
      chk("mr_addr", mem_addr, 0);
      chk("mr_wdata", mem_wdata, 0);
      reset = 1'b0;
      #1;
      chk("mr_rel_ready", s_ready, 1);
      send_frame(1'b0, 12'h123, 8'hA5, 1'b0);
      chk_write("post_rst", 12'h123, 8'hA5);
      send_frame(1'b1, 12'h123, 8'd0, 1'b0);
      chk_read("rd_back", 12'h123, 8'hA5);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
